raster_to_mcu_scheduler: RTL and testbench
==========================================

# raster_to_mcu_scheduler

Sequences the YCbCr pixel stream from the color-space converter, which arrives in raster order, into 8x8 block (MCU) order for the downstream DCT stage. Two 8-line buffer banks in ping-pong arrangement let the write side fill one strip while the read side drains the other. The block sits between color conversion and DCT, and carries frame and block framing on AXI4-Stream sidebands.

## Interface
- IMG_WIDTH, 64: pixels per line; multiple of 8, at least 8.
- IMG_HEIGHT, 64: lines per frame; multiple of 8, at least 8.
- DATA_W, 24: pixel width, packed as {Y, Cb, Cr}.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  DATA_W  raster pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last pixel of a line; checked only.
- s_axis_tuser  in  1  first pixel of a frame.
- m_axis_tdata  out  DATA_W  pixel in block order.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last pixel (64th) of each 8x8 block.
- m_axis_tuser  out  1  first pixel of the first block of a frame.
- line_err  out  1  one-cycle pulse when s_axis_tlast disagrees with the column count.
- sof_err  out  1  one-cycle pulse when s_axis_tuser arrives while not at frame start.

## Operation
- Storage is 2 banks x 8 x IMG_WIDTH x DATA_W. Reads are combinational (register array or distributed RAM).
- Each bank has two flags:
  - full[b]: the bank holds 8 complete lines.
  - sof[b]: the bank holds strip 0 of a frame.
- Write side:
  - Counters: wx (0..W-1), wy (0..7), strip (0..H/8-1), and bank pointer wb.
  - s_axis_tready = !full[wb]. It is a combinational function of registers only.
  - An accept (tvalid && tready) writes the pixel to bank wb at address wy*W+wx, then advances wx.
  - wx wraps to 0 and increments wy. wy wraps to 0 and, in the same edge, sets full[wb], sets sof[wb] = (strip==0), toggles wb, and advances strip. strip wraps to 0 after H/8-1.
- tuser handling:
  - An accepted pixel with s_axis_tuser=1 forces wx=wy=strip=0 before it is written, so it lands at (0,0) of bank wb.
  - If counters were not already all zero, sof_err pulses. The partial bank contents are discarded by being overwritten.
- tlast handling:
  - An accepted pixel where s_axis_tlast != (wx==W-1) pulses line_err.
  - Counting always follows the internal wx, never tlast.
- Read side:
  - Counters: rx (0..7), ry (0..7), bx (0..W/8-1), and bank pointer rb.
  - Load condition: full[rb] && (!m_axis_tvalid || m_axis_tready).
  - On load, the output register takes bank rb at address ry*W + bx*8 + rx, and m_axis_tvalid goes to 1.
  - Sidebands on load: m_axis_tlast = (rx==7 && ry==7); m_axis_tuser = sof[rb] && bx==0 && ry==0 && rx==0.
  - Count order: rx fastest, then ry, then bx.
  - When the last pixel of the bank is loaded (bx=W/8-1, ry=7, rx=7): clear full[rb] and sof[rb], toggle rb, and zero the counters.
  - If m_axis_tready=1 and the load condition is false, m_axis_tvalid goes to 0.
- Simultaneous events:
  - Write-set and read-clear of full flags in the same edge always target different banks; both take effect.
  - A freed bank is writable on the next cycle.
- Reset (asynchronous, mid-operation included):
  - All counters, wb, rb, full, sof and output registers go to 0; buffer contents are don't-care.
  - Outputs in reset: m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0, line_err=sof_err=0, s_axis_tready=1.
  - An in-progress frame is abandoned. The first pixel after reset is treated as (0,0) of strip 0.

## Timing
- Output register: one stage. Latency from bank full to data out is 1 edge.
  - Last pixel of a strip accepted at edge E: full set after E.
  - First block pixel loaded at E+1; m_axis_tvalid=1 after E+1.
- Throughput is 1 pixel/cycle on each side.
- With m_axis_tready held at 1 and continuous input, s_axis_tready never deasserts; a drain of 8W cycles matches a fill of 8W cycles.
- Backpressure:
  - m_axis_tdata, tlast and tuser hold stable while tvalid && !tready.
  - s_axis_tready drops the edge after the second bank fills, and rises the edge after the read side frees bank wb.
- line_err and sof_err are registered, asserted on the edge after the offending accept.

## Test plan
- **Block order:** W=H=16, stream pixel values 0..255 with correct tuser/tlast, m_axis_tready=1.
  - Output sequence is 0..7, 16..23, ..., 112..119, then 8..15, 24..31, ...
  - m_axis_tuser only on value 0; m_axis_tlast on values 119, 127, 247, 255.
- **Latency:** last pixel of line 7 (value 127) accepted at edge E → m_axis_tvalid rises after E+1 with data 0.
- **Backpressure:** m_axis_tready toggled randomly with 30% duty.
  - Identical output sequence, no loss or duplication.
  - Data stable while stalled; s_axis_tready low once both banks are full.
- **Errors:**
  - s_axis_tlast asserted at wx=5 → line_err one pulse; ordering of following pixels unchanged.
  - s_axis_tuser at wy=3 → sof_err one pulse; the next full strip output starts with m_axis_tuser=1.
- **Reset mid-operation:** assert rst_n low mid-drain of bank 1 → all outputs 0 at once, s_axis_tready=1; a fresh frame then produces the correct first block.
- **Continuous streaming:** two back-to-back frames → s_axis_tready stays 1 throughout; m_axis_tuser appears exactly twice, at 256-pixel spacing.

Source files
------------

// File: rtl/raster_to_mcu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : raster_to_mcu_scheduler
// Purpose  : Reorders a raster-order YCbCr pixel stream into 8x8 block (MCU)
//            order. Two 8-line bank buffers in ping-pong: the write side fills
//            one strip while the read side drains the other.
// Ports    : clk, rst_n (async, active-low)
//            s_axis_*  raster input  (tdata/tvalid/tready/tlast/tuser)
//            m_axis_*  block output  (tdata/tvalid/tready/tlast/tuser)
//            line_err  pulse: input tlast disagrees with the column count
//            sof_err   pulse: input tuser arrived while not at frame start
// Revision : 1.0 - initial release
// ============================================================================
module raster_to_mcu_scheduler #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int DATA_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              line_err,
  output logic              sof_err
);

  localparam int DEPTH  = 8 * IMG_WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int XW     = $clog2(IMG_WIDTH);
  localparam int STRIPS = IMG_HEIGHT / 8;
  localparam int SW     = (STRIPS > 1) ? $clog2(STRIPS) : 1;
  localparam int BXN    = IMG_WIDTH / 8;
  localparam int BW     = (BXN > 1) ? $clog2(BXN) : 1;

  // Strip storage: [bank][line*IMG_WIDTH + column]
  logic [DATA_W-1:0] mem [2][DEPTH];

  // Write-side state
  logic [XW-1:0] wx;
  logic [2:0]    wy;
  logic [SW-1:0] strip;
  logic          wb;
  logic [1:0]    full;
  logic [1:0]    sof;

  // Read-side state
  logic [2:0]    rx;
  logic [2:0]    ry;
  logic [BW-1:0] bx;
  logic          rb;

  // ---------------------------------------------------------------- write --
  logic          accept;
  logic [XW-1:0] eff_wx;
  logic [2:0]    eff_wy;
  logic [SW-1:0] eff_strip;
  logic          col_last;
  logic          line_last;
  logic          strip_last;
  logic          at_origin;
  logic [AW-1:0] waddr;

  assign s_axis_tready = !full[wb];
  assign accept        = s_axis_tvalid && s_axis_tready;

  // A frame-start marker re-anchors the pixel to (0,0) of strip 0 before it
  // is written; whatever partial strip was in the bank simply gets overwritten.
  assign eff_wx    = s_axis_tuser ? '0 : wx;
  assign eff_wy    = s_axis_tuser ? '0 : wy;
  assign eff_strip = s_axis_tuser ? '0 : strip;

  assign col_last   = (eff_wx == XW'(IMG_WIDTH - 1));
  assign line_last  = col_last && (eff_wy == 3'd7);
  assign strip_last = (eff_strip == SW'(STRIPS - 1));
  assign at_origin  = (wx == '0) && (wy == '0) && (strip == '0);
  assign waddr      = AW'(eff_wy) * AW'(IMG_WIDTH) + AW'(eff_wx);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wb][waddr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wx       <= '0;
      wy       <= '0;
      strip    <= '0;
      wb       <= 1'b0;
      line_err <= 1'b0;
      sof_err  <= 1'b0;
    end else begin
      line_err <= accept && (s_axis_tlast != col_last);
      sof_err  <= accept && s_axis_tuser && !at_origin;
      if (accept) begin
        wx <= col_last ? '0 : eff_wx + XW'(1);
        wy <= col_last ? eff_wy + 3'd1 : eff_wy;
        if (line_last) begin
          wb    <= ~wb;
          strip <= strip_last ? '0 : eff_strip + SW'(1);
        end else begin
          strip <= eff_strip;
        end
      end
    end
  end

  // ----------------------------------------------------------------- read --
  logic              load;
  logic              rd_last;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] rdata;

  assign load    = full[rb] && (!m_axis_tvalid || m_axis_tready);
  assign rd_last = (bx == BW'(BXN - 1)) && (ry == 3'd7) && (rx == 3'd7);
  assign raddr   = AW'(ry) * AW'(IMG_WIDTH) + AW'({bx, 3'b000}) + AW'(rx);
  assign rdata   = mem[rb][raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx            <= '0;
      ry            <= '0;
      bx            <= '0;
      rb            <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= rdata;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= (rx == 3'd7) && (ry == 3'd7);
      m_axis_tuser  <= sof[rb] && (bx == '0) && (ry == '0) && (rx == '0);
      if (rd_last) begin
        rx <= '0;
        ry <= '0;
        bx <= '0;
        rb <= ~rb;
      end else begin
        rx <= rx + 3'd1;
        if (rx == 3'd7) begin
          ry <= ry + 3'd1;
          if (ry == 3'd7) begin
            bx <= bx + BW'(1);
          end
        end
      end
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // ---------------------------------------------------------- bank flags --
  // The write side only sets a flag on a bank that is not full and the read
  // side only clears a flag on a bank that is full, so the two updates below
  // can never collide on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
      sof  <= 2'b00;
    end else begin
      if (load && rd_last) begin
        full[rb] <= 1'b0;
        sof[rb]  <= 1'b0;
      end
      if (accept && line_last) begin
        full[wb] <= 1'b1;
        sof[wb]  <= (eff_strip == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_raster_to_mcu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_to_mcu_scheduler
// Purpose  : Self-checking bench for raster_to_mcu_scheduler (16x16 frames).
//            A reference model rebuilds each 8-line strip from accepted pixels
//            and emits its expected block-order sequence; outputs, error
//            pulses, stall stability and ready behaviour are compared to it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raster_to_mcu_scheduler;

  localparam int W     = 16;
  localparam int H     = 16;
  localparam int DW    = 24;
  localparam int STRIP = 8 * W;
  localparam int FRAME = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          m_tuser;
  logic          line_err;
  logic          sof_err;

  raster_to_mcu_scheduler #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .s_axis_tuser (s_tuser),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser),
    .line_err     (line_err),
    .sof_err      (sof_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------- model --
  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    logic          user;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] sbuf[STRIP];
  int            p = 0;          // linear pixel position within the frame
  logic          pend_line = 1'b0;
  logic          pend_sof  = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_last, prev_user;
  int            out_idx = 0;
  int            tuser_pos[$];
  int            tready_low = 0;
  int            line_err_cnt = 0;
  int            sof_err_cnt = 0;
  logic          meas = 1'b0;
  int            mode = 0;       // 0: ready high, 1: random 30%, 2: ready low

  task automatic model_accept(input logic [DW-1:0] d, input logic u, input logic l);
    exp_t e;
    if (u) begin
      pend_sof = (p != 0);
      p = 0;
    end
    pend_line = (l != ((p % W) == W - 1));
    sbuf[p % STRIP] = d;
    if ((p % STRIP) == STRIP - 1) begin
      for (int bxi = 0; bxi < W / 8; bxi++)
        for (int ryi = 0; ryi < 8; ryi++)
          for (int rxi = 0; rxi < 8; rxi++) begin
            e.d    = sbuf[ryi * W + bxi * 8 + rxi];
            e.last = (rxi == 7) && (ryi == 7);
            e.user = (p < STRIP) && (bxi == 0) && (ryi == 0) && (rxi == 0);
            exp_q.push_back(e);
          end
    end
    p = (p + 1) % FRAME;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      p = 0;
      exp_q.delete();
      pend_line  = 1'b0;
      pend_sof   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("line_err", 64'(line_err), 64'(pend_line));
      check("sof_err", 64'(sof_err), 64'(pend_sof));
      if (line_err) line_err_cnt++;
      if (sof_err) sof_err_cnt++;
      pend_line = 1'b0;
      pend_sof  = 1'b0;
      if (prev_stall) begin
        check("stall_valid", 64'(m_tvalid), 64'd1);
        check("stall_data", 64'(m_tdata), 64'(prev_d));
        check("stall_last", 64'(m_tlast), 64'(prev_last));
        check("stall_user", 64'(m_tuser), 64'(prev_user));
      end
      if (meas && !s_tready) tready_low++;
      if (s_tvalid && s_tready) model_accept(s_tdata, s_tuser, s_tlast);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(m_tdata), 64'(e.d));
          check("out_last", 64'(m_tlast), 64'(e.last));
          check("out_user", 64'(m_tuser), 64'(e.user));
        end
        if (m_tuser) tuser_pos.push_back(out_idx);
        out_idx++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_last  = m_tlast;
      prev_user  = m_tuser;
    end
  end

  // Downstream ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 99) < 30);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // ------------------------------------------------------------ driver --
  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_px(input logic [DW-1:0] d, input logic u, input logic l);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 5000) begin
        check("s_tready_timeout", 64'd0, 64'd1);
        finish_run();
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 64'(exp_q.size() == 0), 64'd1);
    idle(4);
  endtask

  task automatic send_frame(input bit rnd_data, input bit gaps, input int bad_tlast_at);
    logic [DW-1:0] d;
    for (int i = 0; i < FRAME; i++) begin
      d = rnd_data ? DW'($urandom()) : DW'(i);
      send_px(d, (i == 0), ((i % W) == W - 1) || (i == bad_tlast_at));
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  // -------------------------------------------------------------- main --
  initial begin
    int snap_le, snap_se, snap_tu, snap_low;
    rst_n = 1'b0;
    idle(3);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tuser", 64'(m_tuser), 64'd0);
    check("rst_line_err", 64'(line_err), 64'd0);
    check("rst_sof_err", 64'(sof_err), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd1);
    rst_n = 1'b1;
    idle(2);

    // Block order with values 0..255, plus first-strip latency.
    for (int i = 0; i < FRAME; i++) begin
      send_px(DW'(i), (i == 0), ((i % W) == W - 1));
      if (i == STRIP - 1) begin
        @(negedge clk);
        check("lat_valid_e", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        check("lat_valid_e1", 64'(m_tvalid), 64'd1);
        check("lat_data_e1", 64'(m_tdata), 64'd0);
        @(posedge clk);
        #1;
      end
    end
    wait_drain();

    // Backpressure: fill both banks with downstream stalled.
    mode = 2;
    for (int i = 0; i < FRAME; i++)
      send_px(DW'($urandom()), (i == 0), ((i % W) == W - 1));
    @(negedge clk);
    check("tready_both_full", 64'(s_tready), 64'd0);
    idle(10);
    check("tready_still_low", 64'(s_tready), 64'd0);
    mode = 1;
    send_frame(1'b1, 1'b1, -1);
    send_frame(1'b1, 1'b1, -1);
    wait_drain();

    // Early tlast at column 5 of line 2.
    snap_le = line_err_cnt;
    send_frame(1'b1, 1'b0, 2 * W + 5);
    wait_drain();
    check("line_err_pulses", 64'(line_err_cnt - snap_le), 64'd1);

    // tuser at line 3, column 4: abandon partial strip and restart.
    snap_se = sof_err_cnt;
    for (int i = 0; i < 3 * W + 4; i++)
      send_px(DW'($urandom()), (i == 0), ((i % W) == W - 1));
    send_frame(1'b1, 1'b0, -1);
    wait_drain();
    check("sof_err_pulses", 64'(sof_err_cnt - snap_se), 64'd1);

    // Reset in the middle of draining bank 1.
    send_frame(1'b1, 1'b0, -1);
    idle(40);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("mid_rst_m_tdata", 64'(m_tdata), 64'd0);
    check("mid_rst_m_tlast", 64'(m_tlast), 64'd0);
    check("mid_rst_m_tuser", 64'(m_tuser), 64'd0);
    check("mid_rst_s_tready", 64'(s_tready), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    send_frame(1'b1, 1'b0, -1);
    wait_drain();

    // Two back-to-back frames with downstream always ready.
    snap_tu  = tuser_pos.size();
    snap_low = tready_low;
    meas = 1'b1;
    send_frame(1'b1, 1'b0, -1);
    send_frame(1'b1, 1'b0, -1);
    meas = 1'b0;
    wait_drain();
    check("stream_tready_low", 64'(tready_low - snap_low), 64'd0);
    check("stream_tuser_count", 64'(tuser_pos.size() - snap_tu), 64'd2);
    if (tuser_pos.size() - snap_tu == 2)
      check("stream_tuser_spacing", 64'(tuser_pos[snap_tu + 1] - tuser_pos[snap_tu]), 64'(FRAME));

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    finish_run();
  end

endmodule
`default_nettype wire
